// File: rtl/adder_mp_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package adder_mp_pkg;

    localparam int unsigned LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } state_t;

    // Saturation pattern for one limb: is_top selects the limb holding the sign bit.
    function automatic logic [LIMB_W-1:0] sat_value(input logic sign, input logic is_top);
        if (is_top) begin
            return sign ? {1'b1, {(LIMB_W-1){1'b0}}} : {1'b0, {(LIMB_W-1){1'b1}}};
        end
        return sign ? '0 : '1;
    endfunction

endpackage

// File: rtl/adder.sv
// 16-bit Kogge-Stone prefix adder used as the single-limb datapath.
module adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] w_p0;
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_g_n;
    logic [15:0] w_p_n;

    always_comb begin
        w_p0  = a ^ b;
        w_g   = a & b;
        // Fold carry-in into bit 0 so every group generate already includes it.
        w_g[0] = w_g[0] | (w_p0[0] & cin);
        w_p   = w_p0;
        w_g_n = w_g;
        w_p_n = w_p;
        for (int unsigned lvl = 0; lvl < 4; lvl++) begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (i >= (32'd1 << lvl)) begin
                    w_g_n[i] = w_g[i] | (w_p[i] & w_g[i - (32'd1 << lvl)]);
                    w_p_n[i] = w_p[i] & w_p[i - (32'd1 << lvl)];
                end else begin
                    w_g_n[i] = w_g[i];
                    w_p_n[i] = w_p[i];
                end
            end
            w_g = w_g_n;
            w_p = w_p_n;
        end
        sum  = w_p0 ^ {w_g[14:0], cin};
        cout = w_g[15];
    end

endmodule

// File: rtl/adder_mp_seq.sv
// Multi-precision add/subtract sequencer: one 16-bit limb per cycle through a shared adder.
// Optional macro ADDER_MP_SAT_EN saturates the result on signed overflow.
module adder_mp_seq
    import adder_mp_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_sub,
    input  logic                  req_cin,
    input  logic [16*WORDS-1:0]   req_a,
    input  logic [16*WORDS-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [16*WORDS-1:0]   rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_zero,
    output logic                  rsp_ovf
);

    localparam int unsigned W     = LIMB_W * WORDS;
    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_zero;
    logic               r_ovf;
    logic [IDX_W-1:0]   r_idx;
    logic [LIMB_W-1:0]  w_a_limb;
    logic [LIMB_W-1:0]  w_b_limb;
    logic [LIMB_W-1:0]  w_sum_limb;
    logic               w_cout;
    logic               w_last;
    logic               w_ovf;
    logic               w_zero;
    logic [W-1:0]       w_result;
`ifdef ADDER_MP_SAT_EN
    logic [LIMB_W-1:0]  w_sat_fill;
`endif

    assign w_a_limb = r_a[r_idx*LIMB_W +: LIMB_W];
    assign w_b_limb = r_b[r_idx*LIMB_W +: LIMB_W];

    adder u_adder (
        .a    (w_a_limb),
        .b    (w_b_limb),
        .cin  (r_carry),
        .sum  (w_sum_limb),
        .cout (w_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = RUN;
            end
            RUN: begin
                w_last = (r_idx == LAST_IDX);
                if (w_last) w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Flags are only meaningful in the last RUN cycle; lower limbs already sit in r_sum.
    always_comb begin
        w_ovf    = (r_a[W-1] == r_b[W-1]) && (w_sum_limb[LIMB_W-1] != r_a[W-1]);
        w_result = {w_sum_limb, r_sum[W-LIMB_W-1:0]};
`ifdef ADDER_MP_SAT_EN
        w_sat_fill = sat_value(r_a[W-1], 1'b0);
        if (w_ovf) w_result = {sat_value(r_a[W-1], 1'b1), {(WORDS-1){w_sat_fill}}};
`endif
        w_zero = (w_result == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_a     <= req_a;
                        r_b     <= req_sub ? ~req_b : req_b;
                        r_carry <= req_sub ? 1'b1 : req_cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_sum  <= w_result;
                        r_cout <= w_cout;
                        r_ovf  <= w_ovf;
                        r_zero <= w_zero;
                    end else begin
                        r_sum[r_idx*LIMB_W +: LIMB_W] <= w_sum_limb;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_sum  = r_sum;
    assign rsp_cout = r_cout;
    assign rsp_zero = r_zero;
    assign rsp_ovf  = r_ovf;

endmodule

// File: tb/tb_adder_mp_seq.sv
// Self-checking bench for adder_mp_seq: directed corner cases plus random ops vs an arithmetic model.
module tb_adder_mp_seq;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 16 * WORDS;
    localparam int unsigned W1    = W + 1;
    localparam int unsigned W2    = W + 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_sub;
    logic         req_cin;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_zero;
    logic         rsp_ovf;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] m_sum;
    logic         m_cout;
    logic         m_zero;
    logic         m_ovf;

    adder_mp_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sub   (req_sub),
        .req_cin   (req_cin),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_zero  (rsp_zero),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] r;
        for (int i = 0; i < int'(WORDS); i++) r[i*16 +: 16] = 16'($urandom());
        return r;
    endfunction

    // Reference: plain unsigned and signed arithmetic on the whole operand.
    task automatic model(input logic sub, input logic cin, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W+1:0] sa;
        logic signed [W+1:0] sb;
        logic signed [W+1:0] sr;
        if (sub) begin
            m_sum  = a - b;
            m_cout = (a >= b);
        end else begin
            {m_cout, m_sum} = {1'b0, a} + {1'b0, b} + W1'(cin);
        end
        sa = signed'({{2{a[W-1]}}, a});
        sb = signed'({{2{b[W-1]}}, b});
        sr = sub ? (sa - sb) : (sa + sb + signed'(W2'(cin)));
        m_ovf = (sr[W+1:W-1] != 3'b000) && (sr[W+1:W-1] != 3'b111);
`ifdef ADDER_MP_SAT_EN
        if (m_ovf) m_sum = sr[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        m_zero = (m_sum == '0);
    endtask

    task automatic send(input logic sub, input logic cin, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int waited);
        req_sub   = sub;
        req_cin   = cin;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        model(sub, cin, a, b);
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("accept_ready", W'(req_ready), W'(1'b1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_sub   = 1'($urandom());
        req_cin   = 1'($urandom());
        req_a     = rnd_word();
        req_b     = rnd_word();
    endtask

    task automatic expect_rsp(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, W'(n), W'(WORDS));
        chk({tag, "_sum"},  rsp_sum,       m_sum);
        chk({tag, "_cout"}, W'(rsp_cout),  W'(m_cout));
        chk({tag, "_zero"}, W'(rsp_zero),  W'(m_zero));
        chk({tag, "_ovf"},  W'(rsp_ovf),   W'(m_ovf));
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, W'(rsp_valid), W'(1'b0));
        chk({tag, "_idle_ready"}, W'(req_ready), W'(1'b1));
    endtask

    task automatic op(input logic sub, input logic cin, input logic [W-1:0] a,
                      input logic [W-1:0] b, input string tag);
        int w;
        send(sub, cin, a, b, w);
        expect_rsp(tag);
        release_rsp(tag);
    endtask

    initial begin
        int           w;
        int           seen;
        logic [W-1:0] hold;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_sub   = 1'b0;
        req_cin   = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #1;
        chk("rst_req_ready", W'(req_ready), W'(1'b1));
        chk("rst_rsp_valid", W'(rsp_valid), W'(1'b0));
        chk("rst_rsp_sum",   rsp_sum,       '0);
        chk("rst_flags",     W'({rsp_cout, rsp_zero, rsp_ovf}), '0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        op(1'b0, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1, "carry_chain");
        op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, "full_wrap");
        op(1'b1, 1'b0, 64'h0, 64'h1, "borrow_all");
        op(1'b1, 1'b0, 64'h0000_0000_0001_0000, 64'h1, "borrow_limb");
        op(1'b1, 1'b1, 64'h5, 64'h3, "sub_ignores_cin");
        op(1'b0, 1'b1, 64'h0000_FFFF_FFFF_FFFF, 64'h0, "add_cin");
        op(1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, "pos_ovf");
        op(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h1, "neg_ovf");
        op(1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, "sub_self_zero");

        // Backpressure: response held while new request inputs churn.
        send(1'b0, 1'b0, 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, w);
        expect_rsp("bp_first");
        rsp_ready = 1'b0;
        hold = m_sum;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1;
            req_a     = rnd_word();
            req_b     = rnd_word();
            @(posedge clk); #1;
            chk("bp_valid_hold", W'(rsp_valid), W'(1'b1));
            chk("bp_ready_low",  W'(req_ready), W'(1'b0));
            chk("bp_sum_stable", rsp_sum, hold);
        end
        rsp_ready = 1'b1;
        send(1'b0, 1'b0, 64'h0000_0000_0000_0064, 64'h0000_0000_0000_00C8, w);
        chk("bp_accept_wait", W'(w), W'(1));
        expect_rsp("bp_second");
        release_rsp("bp_second");

        // Asynchronous reset during the second RUN cycle.
        send(1'b0, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, w);
        @(posedge clk); #1;
        chk("mid_run_not_ready", W'(req_ready), W'(1'b0));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", W'(req_ready), W'(1'b1));
        chk("mid_rst_rsp_valid", W'(rsp_valid), W'(1'b0));
        chk("mid_rst_rsp_sum",   rsp_sum,       '0);
        chk("mid_rst_flags",     W'({rsp_cout, rsp_zero, rsp_ovf}), '0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        chk("mid_rst_no_rsp", W'(seen), '0);
        op(1'b0, 1'b0, 64'd3, 64'd4, "after_reset");
        chk("after_reset_seven", m_sum, 64'd7);

        for (int k = 0; k < 40; k++) begin
            ra = rnd_word();
            rb = rnd_word();
            case ($urandom_range(0, 3))
                0: ra = '1;
                1: rb = {1'b1, {(W-1){1'b0}}};
                2: rb = ra;
                default: ;
            endcase
            op(1'($urandom()), 1'($urandom()), ra, rb, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
